alu_16b: RTL and testbench

//   Parameterised registered ALU for the multi-clock-domain system datapath.

---
 rtl/alu_16b_if.sv | 57 +++++
 rtl/alu_16b.sv | 72 +++++++
 tb/tb_alu_16b.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_16b_if.sv
// ---------------------------------------------------------------------------
// alu_16b_if
//   Bundles the operand/operation inputs and the result/class-flag outputs of
//   the alu_16b registered ALU. Clock and reset are not part of the bundle.
//
//   There is no valid/ready handshake on this bus: the ALU samples A, B and
//   ALU_FUN on every rising clock edge and ALU_OUT always holds the result of
//   the most recent capture. The four class flags are a zero-latency decode
//   of ALU_FUN.
//
//   Signals
//     A, B        WIDTH  unsigned operands             (master -> slave)
//     ALU_FUN     4      operation select              (master -> slave)
//     ALU_OUT     WIDTH  registered result             (slave -> master)
//     Arith_Flag  1      ALU_FUN in 0000..0011         (slave -> master)
//     Logic_Flag  1      ALU_FUN in 0100..1001         (slave -> master)
//     CMP_Flag    1      ALU_FUN in 1010..1100         (slave -> master)
//     Shift_Flag  1      ALU_FUN in 1101..1110         (slave -> master)
//
//   Modports
//     master  drives operands/select, observes result and flags
//     slave   the ALU side
// ---------------------------------------------------------------------------
interface alu_16b_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_FUN;
    logic [WIDTH-1:0] ALU_OUT;
    logic             Arith_Flag;
    logic             Logic_Flag;
    logic             CMP_Flag;
    logic             Shift_Flag;

    modport master (
        output A,
        output B,
        output ALU_FUN,
        input  ALU_OUT,
        input  Arith_Flag,
        input  Logic_Flag,
        input  CMP_Flag,
        input  Shift_Flag
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_FUN,
        output ALU_OUT,
        output Arith_Flag,
        output Logic_Flag,
        output CMP_Flag,
        output Shift_Flag
    );
endinterface

// File: rtl/alu_16b.sv
// ---------------------------------------------------------------------------
// alu_16b
//   Registered 16-operation ALU on two unsigned WIDTH-bit operands. The
//   result of the selected operation is captured into ALU_OUT on every rising
//   edge of clk_i. Four one-hot class flags are decoded combinationally from
//   ALU_FUN and do not depend on reset.
//
//   Ports
//     clk_i   in   system clock, rising-edge active
//     rst_i   in   asynchronous active-high reset; forces ALU_OUT to 0
//     bus     alu_16b_if.slave (A, B, ALU_FUN in; ALU_OUT and flags out)
//
//   Operation map (results truncated to WIDTH bits)
//     0000 A+B   0001 A-B   0010 A*B   0011 A/B (B==0 -> 0)
//     0100 A&B   0101 A|B   0110 ~(A&B) 0111 ~(A|B) 1000 A^B 1001 ~(A^B)
//     1010 A==B -> 1   1011 A>B -> 2   1100 A<B -> 3   (else 0)
//     1101 A>>1 (logical)   1110 A<<1   1111 -> 0
// ---------------------------------------------------------------------------
module alu_16b #(
    parameter int WIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_16b_if.slave      bus
);
    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;

    // Next result: a pure function of the current operands and select, so
    // input changes between edges only matter at the next capture.
    always_comb begin
        alu_out_d = '0;
        unique case (bus.ALU_FUN)
            4'b0000: alu_out_d = bus.A + bus.B;
            4'b0001: alu_out_d = bus.A - bus.B;
            4'b0010: alu_out_d = bus.A * bus.B;
            // Divide-by-zero is defined as 0 rather than left to the divider.
            4'b0011: alu_out_d = (bus.B == '0) ? '0 : (bus.A / bus.B);
            4'b0100: alu_out_d = bus.A & bus.B;
            4'b0101: alu_out_d = bus.A | bus.B;
            4'b0110: alu_out_d = ~(bus.A & bus.B);
            4'b0111: alu_out_d = ~(bus.A | bus.B);
            4'b1000: alu_out_d = bus.A ^ bus.B;
            4'b1001: alu_out_d = ~(bus.A ^ bus.B);
            // Compares return distinct small codes so the consumer can tell
            // which comparison produced a nonzero result.
            4'b1010: alu_out_d = (bus.A == bus.B) ? WIDTH'(1) : '0;
            4'b1011: alu_out_d = (bus.A >  bus.B) ? WIDTH'(2) : '0;
            4'b1100: alu_out_d = (bus.A <  bus.B) ? WIDTH'(3) : '0;
            4'b1101: alu_out_d = bus.A >> 1;
            4'b1110: alu_out_d = bus.A << 1;
            default: alu_out_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign bus.ALU_OUT    = alu_out_q;

    // Class flags: disjoint ranges of ALU_FUN, so at most one is ever high
    // and 1111 raises none.
    assign bus.Arith_Flag = (bus.ALU_FUN <= 4'b0011);
    assign bus.Logic_Flag = (bus.ALU_FUN >= 4'b0100) && (bus.ALU_FUN <= 4'b1001);
    assign bus.CMP_Flag   = (bus.ALU_FUN >= 4'b1010) && (bus.ALU_FUN <= 4'b1100);
    assign bus.Shift_Flag = (bus.ALU_FUN == 4'b1101) || (bus.ALU_FUN == 4'b1110);
endmodule

// File: tb/tb_alu_16b.sv
// ---------------------------------------------------------------------------
// tb_alu_16b
//   Self-checking bench for alu_16b: directed vectors from the operation
//   table, boundary cases, reset behaviour, and randomized operations checked
//   against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_16b;
    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    alu_16b_if #(.WIDTH(W)) bus ();

    alu_16b #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Expected results of the random phase, in issue order.
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Computed with plain integer arithmetic modulo 2^16.
    function automatic logic [W-1:0] ref_alu(input int unsigned a, input int unsigned b,
                                             input int unsigned f);
        int unsigned m;
        int unsigned r;
        m = 65536;
        case (f)
            0:  r = (a + b) % m;
            1:  r = (a + m - b) % m;
            2:  r = (a * b) % m;
            3:  r = (b == 0) ? 0 : a / b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = (m - 1) - (a & b);
            7:  r = (m - 1) - (a | b);
            8:  r = a ^ b;
            9:  r = (m - 1) - (a ^ b);
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 2 : 0;
            12: r = (a < b) ? 3 : 0;
            13: r = a / 2;
            14: r = (a * 2) % m;
            default: r = 0;
        endcase
        return W'(r);
    endfunction

    // {Arith, Logic, CMP, Shift}
    function automatic logic [3:0] ref_flags(input int unsigned f);
        if (f <= 3)       return 4'b1000;
        else if (f <= 9)  return 4'b0100;
        else if (f <= 12) return 4'b0010;
        else if (f <= 14) return 4'b0001;
        else              return 4'b0000;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; results are sampled 1 time unit
    // after the rising edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
        @(negedge clk_i);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_FUN = f;
    endtask

    task automatic capture();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i       = 1'b1;
        bus.A       = 16'd15;
        bus.B       = 16'd3;
        bus.ALU_FUN = 4'b0000;
        #2;
        checks++;
        if (bus.ALU_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_initial: ALU_OUT=%h required 0000", bus.ALU_OUT);
        end
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (bus.ALU_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_held: ALU_OUT=%h required 0000", bus.ALU_OUT);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        capture();
        checks++;
        if (bus.ALU_OUT !== 16'd18) begin
            errors++;
            $display("FAIL reset_first_capture: ALU_OUT=%h required 0012", bus.ALU_OUT);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(16'h1234, 16'h0F0F, 4'b0101);
        capture();
        // Assert reset away from any clock edge.
        #2;
        rst_i       = 1'b1;
        bus.ALU_FUN = 4'b1011;
        #1;
        checks++;
        if (bus.ALU_OUT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: ALU_OUT=%h required 0000", bus.ALU_OUT);
        end
        checks++;
        if (dut_flags() !== 4'b0010) begin
            errors++;
            $display("FAIL reset_flags: flags=%b required 0010", dut_flags());
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_directed_a15_b3();
        logic [W-1:0] exp_v [13];
        logic [W-1:0] r;
        exp_v = '{16'd18, 16'd12, 16'd45, 16'd5,
                  16'h0003, 16'h000F, 16'hFFFC, 16'hFFF0, 16'h000C, 16'hFFF3,
                  16'd0, 16'd2, 16'd0};
        for (int i = 0; i < 13; i++) begin
            drive(16'd15, 16'd3, 4'(i));
            #1;
            checks++;
            if (dut_flags() !== ref_flags(i)) begin
                errors++;
                $display("FAIL flags_fun%0d: flags=%b required %b", i, dut_flags(), ref_flags(i));
            end
            capture();
            r = exp_v[i];
            checks++;
            if (bus.ALU_OUT !== r) begin
                errors++;
                $display("FAIL a15_b3_fun%0d: ALU_OUT=%h required %h", i, bus.ALU_OUT, r);
            end
        end
    endtask

    task automatic test_compare_shift();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic [3:0]   tf [6];
        logic [W-1:0] te [6];
        logic [3:0]   tg [6];
        ta = '{16'd3,   16'd7,   16'd4,   16'd4,   16'd4,   16'd7};
        tb = '{16'd15,  16'd7,   16'd0,   16'd0,   16'd0,   16'd8};
        tf = '{4'b1100, 4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b1011};
        te = '{16'd3,   16'd1,   16'd2,   16'd8,   16'd0,   16'd0};
        tg = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], tf[i]);
            #1;
            checks++;
            if (dut_flags() !== tg[i]) begin
                errors++;
                $display("FAIL cmp_shift_flags%0d: flags=%b required %b", i, dut_flags(), tg[i]);
            end
            capture();
            checks++;
            if (bus.ALU_OUT !== te[i]) begin
                errors++;
                $display("FAIL cmp_shift%0d: ALU_OUT=%h required %h", i, bus.ALU_OUT, te[i]);
            end
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic [3:0]   tf [6];
        logic [W-1:0] te [6];
        ta = '{16'hFFFF, 16'h0000, 16'd9,   16'h8001, 16'h8001, 16'hFFFF};
        tb = '{16'h0001, 16'h0001, 16'd0,   16'h0000, 16'h0000, 16'hFFFF};
        tf = '{4'b0000,  4'b0001,  4'b0011, 4'b1110,  4'b1101,  4'b0010};
        te = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0002, 16'h4000, 16'h0001};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], tf[i]);
            capture();
            checks++;
            if (bus.ALU_OUT !== te[i]) begin
                errors++;
                $display("FAIL edge%0d: ALU_OUT=%h required %h", i, bus.ALU_OUT, te[i]);
            end
        end
    endtask

    // Inputs changing between edges must not disturb the held result.
    task automatic test_between_edges();
        drive(16'd100, 16'd23, 4'b0000);
        capture();
        #2;
        bus.A       = 16'h00F0;
        bus.B       = 16'h0F00;
        bus.ALU_FUN = 4'b0101;
        #1;
        checks++;
        if (bus.ALU_OUT !== 16'd123) begin
            errors++;
            $display("FAIL between_edges_hold: ALU_OUT=%h required 007b", bus.ALU_OUT);
        end
        capture();
        checks++;
        if (bus.ALU_OUT !== 16'h0FF0) begin
            errors++;
            $display("FAIL between_edges_next: ALU_OUT=%h required 0ff0", bus.ALU_OUT);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   f;
        logic [W-1:0] e;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'h0000;
                1:       b = a;
                default: b = W'($urandom);
            endcase
            f = 4'($urandom_range(0, 15));
            drive(a, b, f);
            exp_q.push_back(ref_alu(a, b, f));
            #1;
            checks++;
            if (dut_flags() !== ref_flags(f)) begin
                errors++;
                $display("FAIL rand_flags%0d: fun=%b flags=%b required %b", i, f, dut_flags(), ref_flags(f));
            end
            capture();
            e = exp_q.pop_front();
            checks++;
            if (bus.ALU_OUT !== e) begin
                errors++;
                $display("FAIL rand%0d: A=%h B=%h fun=%b ALU_OUT=%h required %h",
                         i, a, b, f, bus.ALU_OUT, e);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed_a15_b3();
        test_compare_shift();
        test_edges();
        test_between_edges();
        test_reset_mid_run();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
